// File: rtl/tt_um_seq_detect_gen2.sv
// Programmable serial-sequence detector: runtime-loaded 1..MAX_LEN bit pattern,
// overlap/non-overlap matching and a saturating match counter.
module tt_um_seq_detect_gen2 #(
  parameter int unsigned MAX_LEN = 8,
  parameter int unsigned CNT_W   = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  typedef enum logic [1:0] {StUnprog, StSearch, StHit} state_e;

  state_e               state_q, state_d;
  logic [7:0]           pat_q, pat_d;
  logic [3:0]           len_q, len_d;
  logic                 ovl_q, ovl_d;
  logic [MAX_LEN-1:0]   hist_q, hist_d;
  logic [3:0]           fill_q, fill_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 match_q, match_d;

  logic                 data_bit, bit_vld, load, cnt_clr;
  logic [3:0]           len_raw, len_dec, fill_inc;
  logic [MAX_LEN-1:0]   hist_shift;
  logic [7:0]           win, mask;
  logic                 hit;

  assign data_bit = ui_in[0];
  assign bit_vld  = ui_in[1];
  assign load     = ui_in[2];
  assign cnt_clr  = ui_in[7];

  assign len_raw  = {1'b0, ui_in[6:4]} + 4'd1;
  assign len_dec  = (len_raw > 4'(MAX_LEN)) ? 4'(MAX_LEN) : len_raw;

  // Window of the last len bits including the one arriving this cycle.
  assign hist_shift = (hist_q << 1) | MAX_LEN'(data_bit);
  assign win        = 8'(hist_shift);
  assign mask       = 8'hFF >> (4'd8 - len_q);
  assign fill_inc   = fill_q + 4'd1;
  assign hit        = (fill_inc >= len_q) && (((win ^ pat_q) & mask) == 8'h00);

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    len_d   = len_q;
    ovl_d   = ovl_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    cnt_d   = cnt_q;
    match_d = match_q;

    if (ena) begin
      if (load) begin
        // Load wins over a same-cycle data bit, which is dropped.
        pat_d   = uio_in;
        len_d   = len_dec;
        ovl_d   = ui_in[3];
        hist_d  = '0;
        fill_d  = '0;
        cnt_d   = '0;
        match_d = 1'b0;
        state_d = StSearch;
      end else begin
        unique case (state_q)
          StUnprog: begin
            match_d = 1'b0;
          end
          StSearch, StHit: begin
            match_d = 1'b0;
            state_d = StSearch;
            if (bit_vld) begin
              hist_d = hist_shift;
              if (hit) begin
                match_d = 1'b1;
                state_d = StHit;
                fill_d  = ovl_q ? len_q : 4'd0;
                if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
              end else begin
                fill_d = (fill_inc > len_q) ? len_q : fill_inc;
              end
            end
          end
          default: begin
            state_d = StUnprog;
            match_d = 1'b0;
          end
        endcase
        if (cnt_clr) cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StUnprog;
      pat_q   <= '0;
      len_q   <= 4'd1;
      ovl_q   <= 1'b0;
      hist_q  <= '0;
      fill_q  <= '0;
      cnt_q   <= '0;
      match_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      ovl_q   <= ovl_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      cnt_q   <= cnt_d;
      match_q <= match_d;
    end
  end

  assign uo_out  = {6'(cnt_q), (state_q != StUnprog), match_q};
  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_tt_um_seq_detect_gen2.sv
// Scoreboard bench for tt_um_seq_detect_gen2: directed scenarios plus random traffic
// checked against a bit-queue reference model.
module tb_tt_um_seq_detect_gen2;

  logic       clk;
  logic       clk_run;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  tt_um_seq_detect_gen2 dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uio_in (uio_in),
    .uo_out (uo_out),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  initial begin
    clk = 1'b0;
    wait (clk_run);
    forever #5 clk = ~clk;
  end

  int         tests = 0;
  int         fails = 0;
  logic [7:0] exp_q[$];

  // Reference model: bits seen since the last load or non-overlap hit.
  bit         m_prog;
  logic [7:0] m_pat;
  int         m_len;
  bit         m_ovl;
  bit         m_bits[$];
  int         m_cnt;
  bit         m_match;

  task automatic check(input string nm, input logic [7:0] got, input logic [7:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %02h expected %02h at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] m_out();
    logic [5:0] c;
    c = 6'(m_cnt);
    return {c, m_prog, m_match};
  endfunction

  task automatic model_reset();
    m_prog = 0; m_pat = 8'h00; m_len = 1; m_ovl = 0;
    m_bits.delete(); m_cnt = 0; m_match = 0;
  endtask

  task automatic model_step(input bit en, input logic [7:0] ui, input logic [7:0] uio);
    bit hit;
    if (!en) return;
    if (ui[2]) begin
      m_prog = 1; m_pat = uio; m_len = int'(ui[6:4]) + 1; m_ovl = ui[3];
      m_bits.delete(); m_cnt = 0; m_match = 0;
    end else if (m_prog) begin
      m_match = 0;
      if (ui[1]) begin
        m_bits.push_back(ui[0]);
        if (m_bits.size() > 8) void'(m_bits.pop_front());
        hit = (m_bits.size() >= m_len);
        for (int i = 0; i < m_len; i++)
          if (hit && (m_bits[m_bits.size() - 1 - i] != m_pat[i])) hit = 0;
        if (hit) begin
          m_match = 1;
          if (m_cnt < 63) m_cnt++;
          if (!m_ovl) m_bits.delete();
        end
      end
    end
    if (ui[7]) m_cnt = 0;
  endtask

  task automatic drive(input bit en, input logic [7:0] ui, input logic [7:0] uio);
    @(negedge clk);
    ena = en; ui_in = ui; uio_in = uio;
    model_step(en, ui, uio);
    exp_q.push_back(m_out());
  endtask

  task automatic bitv(input bit b);
    drive(1'b1, 8'h02 | {7'd0, b}, 8'h00);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  // Monitor: one expected output per driven cycle, sampled just after the edge.
  initial begin
    logic [7:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("uo_out", uo_out, e);
        check("uio_tied", uio_out | uio_oe, 8'h00);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  bit         s2[7] = '{1, 0, 1, 1, 0, 1, 1};
  bit         s4[4] = '{1, 0, 1, 1};
  logic [7:0] ui;
  logic [7:0] c6;
  bit         en;

  initial begin
    clk_run = 0; rst_n = 0; ena = 1; ui_in = 0; uio_in = 0;
    model_reset();
    #3;
    check("reset_uo_out", uo_out, 8'h00);
    check("reset_uio_out", uio_out, 8'h00);
    check("reset_uio_oe", uio_oe, 8'h00);
    rst_n = 1;
    clk_run = 1;

    repeat (5) bitv(1'b1);

    // Overlap
    drive(1'b1, 8'h3C, 8'h0B);
    foreach (s2[i]) bitv(s2[i]);
    settle();
    c6 = uo_out >> 2;
    check("ovl_count", c6, 8'd2);
    check("ovl_last_pulse", uo_out & 8'h03, 8'h03);

    // Non-overlap
    drive(1'b1, 8'h34, 8'h0B);
    foreach (s2[i]) bitv(s2[i]);
    settle();
    c6 = uo_out >> 2;
    check("novl_count1", c6, 8'd1);
    foreach (s4[i]) bitv(s4[i]);
    settle();
    c6 = uo_out >> 2;
    check("novl_count2", c6, 8'd2);

    // Saturation, clear, ena
    drive(1'b1, 8'h04, 8'h01);
    repeat (70) bitv(1'b1);
    settle();
    check("sat_63", uo_out, 8'hFF);
    drive(1'b1, 8'h83, 8'h00);
    settle();
    check("clear_with_hit", uo_out, 8'h03);
    repeat (3) bitv(1'b1);
    repeat (4) drive(1'b0, 8'h83, 8'h00);
    settle();
    check("ena_frozen", uo_out, 8'h0F);
    bitv(1'b0);

    // Reload mid-match, then async reset
    drive(1'b1, 8'h3C, 8'h0B);
    bitv(1'b1); bitv(1'b0); bitv(1'b1);
    drive(1'b1, 8'h27, 8'h05);
    settle();
    check("reload_drops_bit", uo_out, 8'h02);
    bitv(1'b1); bitv(1'b0); bitv(1'b1);
    settle();
    check("reload_match", uo_out, 8'h07);
    bitv(1'b1); bitv(1'b0);
    @(posedge clk);
    #3;
    rst_n = 0; ui_in = 0;
    model_reset();
    #1;
    check("async_reset", uo_out, 8'h00);
    repeat (2) @(negedge clk);
    rst_n = 1;
    bitv(1'b1); bitv(1'b0); bitv(1'b1);
    settle();
    check("no_match_after_reset", uo_out, 8'h00);

    // Random traffic
    drive(1'b1, 8'h1C, 8'h05);
    for (int i = 0; i < 1500; i++) begin
      en = ($urandom_range(0, 9) != 0);
      ui = 8'($urandom);
      ui[1] = ($urandom_range(0, 3) != 0);
      ui[2] = ($urandom_range(0, 39) == 0);
      ui[6] = ($urandom_range(0, 3) == 0);
      ui[7] = ($urandom_range(0, 29) == 0);
      drive(en, ui, 8'($urandom));
    end
    settle();
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL queue_drained: got %0d pending expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tt_um_seq_detect_gen2.md
# tt_um_seq_detect_gen2

Programmable serial-sequence detector: the second-generation FSM user design for the Tiny Tapeout harness. It replaces a fixed-pattern FSM with a runtime-loadable pattern of 1..MAX_LEN bits and a selectable overlap/non-overlap mode. It also adds a saturating match counter. It sits directly under the harness and uses the standard tt_um port set; the cocotb testbench drives it through the tb wrapper.

## Interface
- MAX_LEN, 8: maximum pattern length in bits, range 1..8.
- CNT_W, 6: match-counter width, range 1..6. Zero-extended onto uo_out[7:2].

- clk  in  1  design clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- ena  in  1  harness enable. While low, all state holds.
- ui_in  in  8  [0] serial data bit; [1] bit valid; [2] load strobe; [3] overlap mode (1=overlap); [6:4] pattern length minus 1; [7] synchronous count clear.
- uio_in  in  8  pattern value, sampled only on load.
- uo_out  out  8  [0] match pulse; [1] programmed flag; [7:2] match count.
- uio_out  out  8  tied to 0.
- uio_oe  out  8  tied to 0; all uio pins are inputs.

## Operation
- Registers:
  - pat[7:0], len (1..MAX_LEN), ovl.
  - hist[MAX_LEN-1:0]: shift register, newest bit in the LSB.
  - fill: 0..MAX_LEN.
  - cnt[CNT_W-1:0].
  - match.
  - state.
- Length decode: len = min(ui_in[6:4]+1, MAX_LEN).
- FSM states:
  - UNPROG (reset state): valid bits are ignored and match stays 0. A load moves the FSM to SEARCH.
  - SEARCH: each valid bit is shifted into hist, and fill increments, saturating at len. On a detected hit the FSM goes to HIT.
  - HIT: lasts one cycle. The match output is 1 while in HIT. The FSM evaluates the current cycle's valid bit exactly as in SEARCH, so back-to-back hits stay in HIT. With no hit it returns to SEARCH.
- Hit condition:
  - Applies to a valid bit b in SEARCH or HIT.
  - Requires fill+1 ≥ len.
  - Requires {hist, b} low len bits == pat[len-1:0].
  - pat[len-1] is the first bit received; pat[0] is the last.
- On a hit:
  - ovl=1: fill stays saturated at len, so overlapping occurrences are detected.
  - ovl=0: fill is reset to 0; the next match needs len fresh bits.
  - cnt increments, saturating at 2^CNT_W-1.
- Load (ui_in[2]=1):
  - pat←uio_in, len←decoded value, ovl←ui_in[3].
  - hist, fill, cnt and match are all cleared; state←SEARCH.
  - Load has priority: a valid bit in the same cycle is discarded. Reloading is allowed from any state.
- Count clear (ui_in[7]=1): cnt←0. Clear beats a simultaneous hit increment. The match pulse still fires.
- ena=0: every register holds, including any pending match value. Outputs are static.
- Bits with valid=0 are ignored and never shifted in.
- uio_out and uio_oe are constant 0.

## Timing
- Reset (rst_n low, asynchronous):
  - state=UNPROG; pat, hist, fill, cnt, match=0; len=1; ovl=0.
  - uo_out=0x00 immediately, without waiting for a clock.
  - The first edge after rst_n rises is processed normally.
- Match latency:
  - The completing bit is sampled at edge N.
  - uo_out[0]=1 during cycle N..N+1, exactly one cycle wide per hit.
  - cnt (uo_out[7:2]) updates at the same edge N.
- Programmed flag: uo_out[1]=1 from the edge following the first load until reset.
- A hit on consecutive valid bits (len=1, or overlap) keeps uo_out[0] high across consecutive cycles, with one count per cycle.
- Reset asserted mid-stream discards the pattern. The design requires a new load before any match.

## Test plan
1. Reset state: assert rst_n=0 with no clock running -> uo_out=0x00, uio_out=0x00, uio_oe=0x00; stream valid 1s -> no match, uo_out[1]=0.
2. Overlap mode:
   - Load uio_in=0x0B with ui_in=0x3C (len 4, ovl=1, load), then stream 1,0,1,1,0,1,1.
   - Require match pulses after bits 4 and 7, and uo_out[7:2]=2.
3. Non-overlap mode:
   - Same as scenario 2 with ovl=0 (ui_in=0x34).
   - Require a single pulse after bit 4 and count=1.
   - Stream 1,0,1,1 again; the count must reach 2 only after those 4 fresh bits.
4. Saturation, clear and ena:
   - Load pattern 0x01 with len 1, then stream 70 valid 1s.
   - uo_out[0] must stay high continuously and uo_out[7:2] must saturate at 63.
   - Assert ui_in[7] together with a hit -> count=0 and the pulse still present.
   - Drop ena mid-stream -> count and outputs frozen.
5. Load and reset mid-operation:
   - After 3 of 4 matching bits, load uio_in=0x05 with len 3 while driving a valid bit -> that bit is ignored and no match occurs. Stream 1,0,1 -> one match.
   - Assert rst_n=0 asynchronously mid-stream -> uo_out=0x00 at once; later bits do not match until a reload.
